// File: rtl/lsu_pkg.sv
// Shared types for the LSU data-cache port: funct3 encodings, FSM states and
// the request record carried through the issue queue.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Tag width of the queued record; the top-level TAG_W defaults to this.
  localparam int LSU_TAG_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_e;

  typedef struct packed {
    logic                 store;
    logic [2:0]           funct3;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [LSU_TAG_W-1:0] tag;
  } lsu_req_t;

endpackage

// File: rtl/lsu_req_fifo.sv
// In-order request queue of lsu_req_t entries with a synchronous clear.
// The head entry is presented combinationally on rdata.
module lsu_req_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  logic     clear,
  input  lsu_req_t wdata,
  output lsu_req_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  lsu_req_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: registers use <= so every flop samples pre-edge values and updates together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lsu_dcache_port.sv
// LSU back-end: queues load/store ops, drives the data cache one op at a time
// and returns extended load data or a store acknowledge with the op's tag.
module lsu_dcache_port
  import lsu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = LSU_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_store,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_data,
  input  logic             flush,
  output logic [31:0]      dc_address,
  output logic [3:0]       dc_we,
  output logic [31:0]      dc_wdata,
  input  logic [31:0]      dc_rdata,
  input  logic             dc_valid
);

  function automatic logic [3:0] store_be(input logic [2:0] f3);
    case (f3)
      F3_B:    return 4'b0001;
      F3_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    return {{24{d[7]}}, d[7:0]};
      F3_H:    return {{16{d[15]}}, d[15:0]};
      F3_BU:   return {24'h0, d[7:0]};
      F3_HU:   return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  lsu_req_t         push_req;
  lsu_req_t         head;
  logic             q_full;
  logic             q_empty;
  logic             q_pop;
  lsu_state_e       state;
  logic             cur_store;
  logic [2:0]       cur_funct3;
  logic [TAG_W-1:0] cur_tag;

  assign req_ready = !q_full;
  assign push_req  = '{store: req_store, funct3: req_funct3, addr: req_addr,
                       wdata: req_wdata, tag: req_tag};
  assign q_pop     = (state == IDLE) && !q_empty && !flush;

  lsu_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid && req_ready),
    .pop   (q_pop),
    .clear (flush),
    .wdata (push_req),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty)
  );

  // A flushed load is abandoned silently; a store always acknowledges since
  // the cache may already have been written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dc_address <= '0;
      dc_we      <= '0;
      dc_wdata   <= '0;
      resp_valid <= 1'b0;
      resp_store <= 1'b0;
      resp_tag   <= '0;
      resp_data  <= '0;
      cur_store  <= 1'b0;
      cur_funct3 <= '0;
      cur_tag    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (q_pop) begin
            dc_address <= head.addr;
            dc_wdata   <= head.wdata;
            dc_we      <= head.store ? store_be(head.funct3) : 4'b0000;
            cur_store  <= head.store;
            cur_funct3 <= head.funct3;
            cur_tag    <= head.tag;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // dc_valid may still describe the previous address this cycle.
          state <= (flush && !cur_store) ? IDLE : WAIT;
        end
        WAIT: begin
          if (flush && !cur_store) begin
            state <= IDLE;
          end else if (dc_valid) begin
            resp_data  <= cur_store ? 32'h0 : load_ext(cur_funct3, dc_rdata);
            resp_tag   <= cur_tag;
            resp_store <= cur_store;
            resp_valid <= 1'b1;
            dc_we      <= 4'b0000;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dcache_port.sv
// Self-checking bench for lsu_dcache_port: byte-addressed cache model with a
// programmable settle delay, and a memory/queue reference model for results.
module tb_lsu_dcache_port;
  import lsu_pkg::*;

  localparam int TAG_W = 5;

  typedef struct {
    bit          store;
    logic [4:0]  tag;
    logic [31:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_store;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_data;
  logic             flush;
  logic [31:0]      dc_address;
  logic [3:0]       dc_we;
  logic [31:0]      dc_wdata;
  logic [31:0]      dc_rdata;
  logic             dc_valid;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cache_d = 0;
  int          stable  = 100;
  logic [31:0] prev_addr = '0;
  logic [7:0]  cmem    [512];
  logic [7:0]  ref_mem [512];
  exp_t        exp_q [$];
  logic [31:0] last_data;

  always #5 clk = ~clk;

  lsu_dcache_port #(.FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_store (resp_store),
    .resp_tag   (resp_tag),
    .resp_data  (resp_data),
    .flush      (flush),
    .dc_address (dc_address),
    .dc_we      (dc_we),
    .dc_wdata   (dc_wdata),
    .dc_rdata   (dc_rdata),
    .dc_valid   (dc_valid)
  );

  // Cache model: byte array, writes on every edge with dc_we set, valid once
  // the address has been stable for cache_d cycles.
  assign dc_rdata = {cmem[9'(dc_address + 32'd3)], cmem[9'(dc_address + 32'd2)],
                     cmem[9'(dc_address + 32'd1)], cmem[dc_address[8:0]]};
  assign dc_valid = (stable >= cache_d);

  initial begin
    for (int i = 0; i < 512; i++) cmem[i] = 8'(i % 255);
    forever begin
      @(posedge clk);
      for (int i = 0; i < 4; i++)
        if (dc_we[i]) cmem[9'(dc_address + 32'(i))] <= dc_wdata[8*i +: 8];
      stable    <= (dc_address != prev_addr) ? 0 : ((stable < 1000) ? stable + 1 : stable);
      prev_addr <= dc_address;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  // Reference: memory as a byte array, results from RISC-V size/sign rules.
  function automatic exp_t model_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wd, input logic [4:0] tag);
    exp_t        e;
    int          n;
    bit          sgn;
    logic [31:0] v;
    e.store = st;
    e.tag   = tag;
    e.data  = 32'h0;
    if (st) begin
      n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int i = 0; i < n; i++) ref_mem[9'(addr + 32'(i))] = wd[8*i +: 8];
    end else begin
      case (f3)
        3'd0:    begin n = 1; sgn = 1'b1; end
        3'd1:    begin n = 2; sgn = 1'b1; end
        3'd4:    begin n = 1; sgn = 1'b0; end
        3'd5:    begin n = 2; sgn = 1'b0; end
        default: begin n = 4; sgn = 1'b0; end
      endcase
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[9'(addr + 32'(i))]) << (8 * i));
      if (sgn && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      e.data = v;
    end
    return e;
  endfunction

  task automatic push(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] tag);
    int n = 0;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_tag    = tag;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("push_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] tag);
    exp_q.push_back(model_op(st, f3, addr, wd, tag));
    push(st, f3, addr, wd, tag);
  endtask

  task automatic collect();
    exp_t e;
    int   n = 0;
    e = exp_q.pop_front();
    resp_ready = 1'b1;
    while (!resp_valid && n < 200) begin @(posedge clk); #1; n++; end
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_store", 32'(resp_store), 32'(e.store));
    check("resp_tag", 32'(resp_tag), 32'(e.tag));
    check("resp_data", resp_data, e.data);
    last_data = resp_data;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  // Single op into an idle port: address/enable timing, latency, then result.
  task automatic run_timed(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] tag,
                           input logic [3:0] be, input int lat);
    int n;
    send(st, f3, addr, wd, tag);
    @(posedge clk); #1;
    check("dc_address", dc_address, addr);
    check("dc_we", 32'(dc_we), 32'(be));
    check("dc_wdata", dc_wdata, wd);
    n = 1;
    while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("latency", 32'(n), 32'(lat));
    collect();
  endtask

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  tag;
    int          k;
    int          n;
    exp_t        e;

    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; req_tag = '0; resp_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'(i % 255);
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_dc_we", 32'(dc_we), 32'd0);
    check("rst_dc_address", dc_address, 32'd0);
    check("rst_dc_wdata", dc_wdata, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_tag", 32'(resp_tag), 32'd0);
    check("rst_resp_store", 32'(resp_store), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed loads/stores with D = 0
    cache_d = 0;
    run_timed(1'b0, F3_W, 32'h10, 32'h0, 5'd3, 4'h0, 3);
    check("lit_lw_10", last_data, 32'h13121110);
    run_timed(1'b0, F3_B, 32'h80, 32'h0, 5'd4, 4'h0, 3);
    check("lit_lb_80", last_data, 32'hFFFFFF80);
    run_timed(1'b0, F3_BU, 32'h80, 32'h0, 5'd5, 4'h0, 3);
    check("lit_lbu_80", last_data, 32'h00000080);
    run_timed(1'b0, F3_H, 32'hFE, 32'h0, 5'd6, 4'h0, 3);
    check("lit_lh_fe", last_data, 32'h000000FE);
    run_timed(1'b1, F3_W, 32'h20, 32'hDEADBEEF, 5'd7, 4'hF, 3);
    run_timed(1'b0, F3_W, 32'h20, 32'h0, 5'd8, 4'h0, 3);
    check("lit_lw_20", last_data, 32'hDEADBEEF);
    run_timed(1'b1, F3_B, 32'h21, 32'h00000055, 5'd9, 4'h1, 3);
    run_timed(1'b0, F3_H, 32'h22, 32'h0, 5'd10, 4'h0, 3);
    check("lit_lh_22", last_data, 32'hFFFFDEAD);
    run_timed(1'b0, F3_W, 32'h20, 32'h0, 5'd11, 4'h0, 3);
    check("lit_lw_20b", last_data, 32'hDEAD55EF);

    // Cache delay of 3, then a repeat of the same address
    cache_d = 3;
    run_timed(1'b0, F3_W, 32'h40, 32'h0, 5'd12, 4'h0, 6);
    check("lit_lw_40", last_data, 32'h43424140);
    run_timed(1'b0, F3_W, 32'h40, 32'h0, 5'd13, 4'h0, 3);

    // Flush in WAIT of a load with two ops queued and a simultaneous push
    cache_d = 5;
    push(1'b0, F3_W, 32'h180, 32'h0, 5'd20);
    push(1'b0, F3_W, 32'h184, 32'h0, 5'd21);
    push(1'b0, F3_W, 32'h188, 32'h0, 5'd22);
    flush = 1'b1;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = F3_W; req_addr = 32'h18C; req_tag = 5'd23;
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    check("flush_no_resp", 32'(resp_valid), 32'd0);
    check("flush_no_pop", dc_address, 32'h180);
    run_timed(1'b0, F3_W, 32'h1A0, 32'h0, 5'd24, 4'h0, 8);

    // Flush held across ISSUE/WAIT of a store, then again while in RESP
    cache_d = 4;
    send(1'b1, F3_W, 32'h1C0, 32'hCAFEF00D, 5'd25);
    @(posedge clk); #1;
    flush = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("store_ack_valid", 32'(resp_valid), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("resp_hold_valid", 32'(resp_valid), 32'd1);
    check("resp_hold_tag", 32'(resp_tag), 32'd25);
    collect();
    run_timed(1'b0, F3_W, 32'h1C0, 32'h0, 5'd26, 4'h0, 3);
    check("lit_lw_1c0", last_data, 32'hCAFEF00D);

    // Backpressure: five ops with resp_ready low
    cache_d = 1;
    send(1'b1, F3_H, 32'h100, 32'h0000A5C3, 5'd10);
    send(1'b0, F3_W, 32'h100, 32'h0, 5'd11);
    send(1'b0, F3_BU, 32'h101, 32'h0, 5'd12);
    send(1'b1, F3_B, 32'h102, 32'h0000007E, 5'd13);
    send(1'b0, F3_H, 32'h101, 32'h0, 5'd14);
    check("bp_full", 32'(req_ready), 32'd0);
    repeat (6) begin @(posedge clk); #1; end
    check("bp_still_full", 32'(req_ready), 32'd0);
    check("bp_head_valid", 32'(resp_valid), 32'd1);
    check("bp_head_tag", 32'(resp_tag), 32'd10);
    for (int j = 0; j < 5; j++) collect();

    // Randomised batches
    for (int b = 0; b < 20; b++) begin
      cache_d = $urandom_range(0, 2);
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        st   = 1'($urandom_range(0, 1));
        f3   = 3'($urandom_range(0, 7));
        addr = 32'($urandom_range(0, 'h1F0));
        wd   = $urandom;
        tag  = 5'($urandom);
        send(st, f3, addr, wd, tag);
      end
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      for (int j = 0; j < k; j++) collect();
    end

    // Reset asserted while a store waits on the cache
    cache_d = 6;
    e = model_op(1'b1, F3_W, 32'h60, 32'h600DF00D, 5'd27);
    push(1'b1, F3_W, 32'h60, 32'h600DF00D, 5'd27);
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_dc_we", 32'(dc_we), 32'hF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dc_we", 32'(dc_we), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_dc_address", dc_address, 32'd0);
    check("mid_rst_ack_store", 32'(e.store), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cache_d = 0;
    run_timed(1'b0, F3_W, 32'h10, 32'h0, 5'd28, 4'h0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
